// File: rtl/sample_scanner.sv
// sample_scanner: periodic channel scanner strobing pin controllers and buffering captures in a FWFT FIFO
module sample_scanner #(
    parameter int          NUM_CHANNELS = 10,
    parameter logic [18:0] BASE_ADDR    = 19'd240,
    parameter int          FIFO_AW      = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_bus_en,
    input  logic               cmd_bus_wr,
    input  logic [18:0]        cmd_bus_addr,
    input  logic [31:0]        cmd_bus_data,
    output logic               output_sample,
    output logic [7:0]         channel_select,
    input  logic [31:0]        sample_data,
    output logic [31:0]        fifo_dout,
    input  logic               fifo_rd_en,
    output logic               fifo_empty,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, WAIT, SELECT, CAPTURE} state_t;
    state_t state, state_nxt;
    logic we, run, clear, reload, push, full, do_push, do_pop, has_next, unused_bits;
    logic [NUM_CHANNELS-1:0] mask;
    logic [31:0] period, pcnt;
    logic [7:0] ch_nxt, first_ch, next_ch;
    logic [FIFO_AW-1:0] wp, rp;
    logic [31:0] mem [2**FIFO_AW];

    assign we = cmd_bus_en & cmd_bus_wr;
    assign clear = we && cmd_bus_addr == BASE_ADDR && cmd_bus_data[1];
    assign output_sample = state == SELECT;
    assign busy = state == SELECT || state == CAPTURE;
    assign full = fifo_count[FIFO_AW];
    assign fifo_empty = fifo_count == '0;
    assign do_push = push & ~full;
    assign do_pop = fifo_rd_en & ~fifo_empty;
    assign fifo_dout = fifo_empty ? '0 : mem[rp];
    assign unused_bits = ^sample_data[31:24];

    // configuration registers written from the scheduler command bus
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            run <= 1'b0;
            mask <= '0;
            period <= '0;
        end else if (we) begin
            if (cmd_bus_addr == BASE_ADDR) run <= cmd_bus_data[0];
            if (cmd_bus_addr == BASE_ADDR + 19'd1) mask <= cmd_bus_data[NUM_CHANNELS-1:0];
            if (cmd_bus_addr == BASE_ADDR + 19'd2) period <= cmd_bus_data;
        end

    // lowest enabled channel and lowest enabled channel above the current one
    always_comb begin
        first_ch = '0;
        next_ch = '0;
        has_next = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) first_ch = 8'(i);
            if (mask[i] && 8'(i) > channel_select) begin
                next_ch = 8'(i);
                has_next = 1'b1;
            end
        end
    end

    // scan sequencing: next state, next channel, period reload and capture push
    always_comb begin
        state_nxt = state;
        ch_nxt = channel_select;
        reload = 1'b0;
        push = 1'b0;
        case (state)
            IDLE: if (run && |mask) begin
                state_nxt = SELECT;
                ch_nxt = first_ch;
                reload = 1'b1;
            end
            WAIT: if (!run) state_nxt = IDLE;
                else if (pcnt == '0 && |mask) begin
                    state_nxt = SELECT;
                    ch_nxt = first_ch;
                    reload = 1'b1;
                end
            SELECT: state_nxt = CAPTURE;
            CAPTURE: begin
                push = 1'b1;
                if (!run) state_nxt = IDLE;
                else if (has_next) begin
                    state_nxt = SELECT;
                    ch_nxt = next_ch;
                end else if (pcnt == '0 && |mask) begin
                    state_nxt = SELECT;
                    ch_nxt = first_ch;
                    reload = 1'b1;
                end else state_nxt = WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and the held channel select
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            channel_select <= '0;
        end else begin
            state <= state_nxt;
            channel_select <= ch_nxt;
        end

    // period counter: reloaded at scan start, saturating countdown otherwise
    always_ff @(posedge clk or posedge rst)
        if (rst) pcnt <= '0;
        else if (reload) pcnt <= (period == '0) ? '0 : period - 32'd1;
        else if (pcnt != '0) pcnt <= pcnt - 32'd1;

    // FIFO pointers, occupancy and sticky overflow; CLEAR overrides push and pop
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wp <= wp + FIFO_AW'(1);
            if (do_pop) rp <= rp + FIFO_AW'(1);
            fifo_count <= fifo_count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
            if (push && full) overflow <= 1'b1;
        end

    // capture storage, tagged with the channel it came from
    always_ff @(posedge clk)
        if (do_push && !clear) mem[wp] <= {channel_select, sample_data[23:0]};
endmodule
